// File: rtl/pwm_fade_sequencer.sv
// PWM breathing sequencer: prescaler -> slot counter -> compare, with a fade FSM
// that ramps duty up, holds high, ramps down, holds low, then loops or finishes.
module pwm_fade_sequencer #(
    parameter int MAIN_FREQ    = 50000000,
    parameter int PWM_FREQ     = 5000,
    parameter int DUTY_BITS    = 8,
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_PERIODS = 50
) (
    input  logic                 CLOCK_50,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [DUTY_BITS-1:0] step_size,
    output logic                 pwm_out,
    output logic [DUTY_BITS-1:0] duty,
    output logic [2:0]           phase,
    output logic                 busy,
    output logic                 done
);

    localparam int DIV_RAW = MAIN_FREQ / (PWM_FREQ << DUTY_BITS);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int HW      = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam logic [DUTY_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [DUTY_BITS-1:0] SLOT_LAST = '1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } phase_t;

    phase_t                 state, state_next;
    logic [TW-1:0]          tick_cnt, tick_next;
    logic [DUTY_BITS-1:0]   slot, slot_next;
    logic [DUTY_BITS-1:0]   duty_next;
    logic [DUTY_BITS-1:0]   step_eff, step_eff_next;
    logic [SW-1:0]          step_cnt, step_cnt_next;
    logic [HW-1:0]          hold_cnt, hold_next;
    logic                   slot_tick, period_end, busy_next, pwm_next, done_next;

    // Sum is formed one bit wider so the carry flags overflow past full scale.
    function automatic logic [DUTY_BITS-1:0] sat_add(input logic [DUTY_BITS-1:0] a,
                                                     input logic [DUTY_BITS-1:0] b);
        logic [DUTY_BITS:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DUTY_BITS] ? DUTY_MAX : sum[DUTY_BITS-1:0];
    endfunction

    function automatic logic [DUTY_BITS-1:0] sat_sub(input logic [DUTY_BITS-1:0] a,
                                                     input logic [DUTY_BITS-1:0] b);
        return (b >= a) ? '0 : a - b;
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            slot     <= '0;
            duty     <= '0;
            step_eff <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
            pwm_out  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            slot     <= slot_next;
            duty     <= duty_next;
            step_eff <= step_eff_next;
            step_cnt <= step_cnt_next;
            hold_cnt <= hold_next;
            pwm_out  <= pwm_next;
            done     <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        duty_next     = duty;
        step_eff_next = step_eff;
        step_cnt_next = step_cnt;
        hold_next     = hold_cnt;
        done_next     = 1'b0;
        slot_tick     = (state != IDLE) && (tick_cnt == TW'(DIV - 1));
        period_end    = slot_tick && (slot == SLOT_LAST);

        // Timebase only runs while a sequence is active.
        if (state == IDLE) begin
            tick_next = '0;
            slot_next = '0;
        end else begin
            tick_next = slot_tick ? '0 : tick_cnt + 1'b1;
            slot_next = slot_tick ? slot + 1'b1 : slot;
        end

        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next    = RAMP_UP;
                    duty_next     = '0;
                    step_cnt_next = '0;
                    hold_next     = '0;
                    step_eff_next = (step_size == '0) ? DUTY_BITS'(1) : step_size;
                end
            end
            RAMP_UP: begin
                if (period_end) begin
                    if (step_cnt == SW'(STEP_PERIODS - 1)) begin
                        step_cnt_next = '0;
                        duty_next     = sat_add(duty, step_eff);
                        if (duty_next == DUTY_MAX) begin
                            state_next = HOLD_HIGH;
                            hold_next  = '0;
                        end
                    end else begin
                        step_cnt_next = step_cnt + 1'b1;
                    end
                end
            end
            HOLD_HIGH: begin
                if (period_end) begin
                    if (hold_cnt == HW'(HOLD_PERIODS - 1)) begin
                        hold_next     = '0;
                        step_cnt_next = '0;
                        state_next    = RAMP_DOWN;
                    end else begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end
            end
            RAMP_DOWN: begin
                if (period_end) begin
                    if (step_cnt == SW'(STEP_PERIODS - 1)) begin
                        step_cnt_next = '0;
                        duty_next     = sat_sub(duty, step_eff);
                        if (duty_next == '0) begin
                            state_next = HOLD_LOW;
                            hold_next  = '0;
                        end
                    end else begin
                        step_cnt_next = step_cnt + 1'b1;
                    end
                end
            end
            HOLD_LOW: begin
                if (period_end) begin
                    if (hold_cnt == HW'(HOLD_PERIODS - 1)) begin
                        hold_next     = '0;
                        step_cnt_next = '0;
                        if (loop_en) begin
                            state_next = RAMP_UP;
                        end else begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                            tick_next  = '0;
                            slot_next  = '0;
                        end
                    end else begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (state != IDLE && stop) begin
            state_next    = IDLE;
            duty_next     = '0;
            tick_next     = '0;
            slot_next     = '0;
            step_cnt_next = '0;
            hold_next     = '0;
            done_next     = 1'b0;
        end

        // Compare against next-state slot and duty so each period starts clean.
        busy_next = (state_next != IDLE);
        pwm_next  = busy_next && (slot_next < duty_next);
    end

    always_comb begin
        phase = state;
        busy  = (state != IDLE);
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: directed vector table, hand sequences for
// multi-cycle corners, and random stimulus against a per-period schedule model.
module tb_pwm_fade_sequencer;

    localparam int DB    = 4;
    localparam int MAXD  = 15;
    localparam int PER   = 16;
    localparam int STEPP = 1;
    localparam int HOLDP = 2;

    logic          CLOCK_50 = 1'b0;
    logic          rst = 1'b1, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [DB-1:0] step_size = '0;
    logic          pwm_out, busy, done;
    logic [DB-1:0] duty;
    logic [2:0]    phase;

    int vectors = 0;
    int miscompares = 0;

    pwm_fade_sequencer #(
        .MAIN_FREQ(64), .PWM_FREQ(4), .DUTY_BITS(DB),
        .STEP_PERIODS(STEPP), .HOLD_PERIODS(HOLDP)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .start(start), .stop(stop),
        .loop_en(loop_en), .step_size(step_size), .pwm_out(pwm_out),
        .duty(duty), .phase(phase), .busy(busy), .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference: a whole sequence is a list of (phase, duty) per PWM period.
    int  sp[$];
    int  sd[$];
    int  m_len = 0;
    int  m_k = 0;
    bit  m_busy = 1'b0;
    bit  m_done = 1'b0;

    task automatic push(input int ph, input int du);
        sp.push_back(ph);
        sd.push_back(du);
    endtask

    task automatic build_sched(input int s);
        int d;
        sp.delete();
        sd.delete();
        d = 0;
        do begin
            for (int i = 0; i < STEPP; i++) push(1, d);
            d = (d + s > MAXD) ? MAXD : d + s;
        end while (d != MAXD);
        for (int i = 0; i < HOLDP; i++) push(2, MAXD);
        do begin
            for (int i = 0; i < STEPP; i++) push(3, d);
            d = (d - s < 0) ? 0 : d - s;
        end while (d != 0);
        for (int i = 0; i < HOLDP; i++) push(4, 0);
        m_len = sp.size();
    endtask

    task automatic model_step();
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_k    = 0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (start && !stop) begin
                build_sched((step_size == 0) ? 1 : int'(step_size));
                m_busy = 1'b1;
                m_k    = 0;
            end
        end else if (stop) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            m_k++;
            if (m_k == m_len * PER) begin
                if (loop_en) m_k = 0;
                else begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input int eph, input int edu,
                         input bit ebusy, input bit edone, input bit epwm);
        vectors++;
        if (phase !== 3'(eph) || duty !== DB'(edu) || busy !== ebusy ||
            done !== edone || pwm_out !== epwm) begin
            miscompares++;
            $display("FAIL %s: got phase=%0d duty=%0d busy=%b done=%b pwm=%b, expected phase=%0d duty=%0d busy=%b done=%b pwm=%b",
                     name, phase, duty, busy, done, pwm_out, eph, edu, ebusy, edone, epwm);
        end
    endtask

    task automatic check_model(input string name);
        int p, s;
        if (m_busy) begin
            p = m_k / PER;
            s = m_k % PER;
            check(name, sp[p], sd[p], 1'b1, 1'b0, s < sd[p]);
        end else begin
            check(name, 0, 0, 1'b0, m_done, 1'b0);
        end
    endtask

    typedef struct {
        bit r, s, p, l;
        int step, cycles;
        int ph, du;
        bit b, d, w;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, bit p, bit l, int step, int cycles,
                                int ph, int du, bit b, bit d, bit w);
        vec_t v;
        v.r = r; v.s = s; v.p = p; v.l = l; v.step = step; v.cycles = cycles;
        v.ph = ph; v.du = du; v.b = b; v.d = d; v.w = w;
        return v;
    endfunction

    vec_t vt[18];

    initial begin
        int cnt;
        // rst start stop loop step cycles | phase duty busy done pwm
        vt[0]  = mk(1, 0, 0, 0, 0, 3,    0,  0, 0, 0, 0);
        vt[1]  = mk(0, 1, 0, 0, 5, 1,    1,  0, 1, 0, 0);
        vt[2]  = mk(0, 0, 0, 0, 5, 16,   1,  5, 1, 0, 1);
        vt[3]  = mk(0, 0, 0, 0, 5, 5,    1,  5, 1, 0, 0);
        vt[4]  = mk(0, 0, 0, 0, 5, 11,   1, 10, 1, 0, 1);
        vt[5]  = mk(0, 0, 0, 0, 5, 16,   2, 15, 1, 0, 1);
        vt[6]  = mk(0, 0, 0, 0, 5, 15,   2, 15, 1, 0, 0);
        vt[7]  = mk(0, 0, 0, 0, 5, 17,   3, 15, 1, 0, 1);
        vt[8]  = mk(0, 0, 0, 0, 5, 16,   3, 10, 1, 0, 1);
        vt[9]  = mk(0, 0, 0, 0, 5, 32,   4,  0, 1, 0, 0);
        vt[10] = mk(0, 0, 0, 0, 5, 31,   4,  0, 1, 0, 0);
        vt[11] = mk(0, 0, 0, 0, 5, 1,    0,  0, 0, 1, 0);
        vt[12] = mk(0, 0, 0, 0, 5, 1,    0,  0, 0, 0, 0);
        vt[13] = mk(0, 1, 1, 0, 5, 1,    0,  0, 0, 0, 0);
        vt[14] = mk(0, 1, 0, 0, 0, 1,    1,  0, 1, 0, 0);
        vt[15] = mk(0, 0, 0, 0, 0, 239,  1, 14, 1, 0, 0);
        vt[16] = mk(0, 0, 0, 0, 0, 1,    2, 15, 1, 0, 1);
        vt[17] = mk(0, 0, 1, 0, 0, 1,    0,  0, 0, 0, 0);

        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            step_size = DB'($urandom);
            tick();
            check_model("warmup");
        end

        foreach (vt[i]) begin
            rst = vt[i].r; start = vt[i].s; stop = vt[i].p;
            loop_en = vt[i].l; step_size = DB'(vt[i].step);
            for (int c = 0; c < vt[i].cycles; c++) begin
                tick();
                if (c == 0) begin
                    start = 1'b0;
                    stop  = 1'b0;
                end
            end
            check($sformatf("vec%0d", i), vt[i].ph, vt[i].du, vt[i].b, vt[i].d, vt[i].w);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;

        // High-time per period tracks duty through a whole fade.
        start = 1'b1; step_size = 4'd5; loop_en = 1'b0;
        tick();
        start = 1'b0;
        for (int p = 0; p < 10; p++) begin
            int exp_hi [10] = '{0, 5, 10, 15, 15, 15, 10, 5, 0, 0};
            cnt = 0;
            for (int c = 0; c < PER; c++) begin
                cnt += int'(pwm_out);
                tick();
            end
            vectors++;
            if (cnt != exp_hi[p]) begin
                miscompares++;
                $display("FAIL hightime_p%0d: got %0d high cycles, expected %0d", p, cnt, exp_hi[p]);
            end
        end
        check("fade_done", 0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        check("fade_after", 0, 0, 1'b0, 1'b0, 1'b0);

        // Abort during ramp-down at duty 10.
        start = 1'b1; step_size = 4'd5;
        tick();
        start = 1'b0;
        repeat (96) tick();
        check("abort_pre", 3, 10, 1'b1, 1'b0, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("abort_post", 0, 0, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            cnt += int'(done);
            tick();
        end
        vectors++;
        if (cnt != 0) begin
            miscompares++;
            $display("FAIL abort_done: got %0d done cycles, expected 0", cnt);
        end

        // Restart while ramping is ignored; step 5 is kept.
        start = 1'b1; step_size = 4'd5;
        tick();
        start = 1'b0;
        repeat (20) tick();
        start = 1'b1; step_size = 4'd3;
        tick();
        start = 1'b0;
        repeat (11) tick();
        check("restart_ignored", 1, 10, 1'b1, 1'b0, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Looping, then reset in HOLD_HIGH.
        start = 1'b1; step_size = 4'd5; loop_en = 1'b1;
        tick();
        start = 1'b0;
        repeat (160) tick();
        check("loop_wrap", 1, 0, 1'b1, 1'b0, 1'b0);
        repeat (16) tick();
        check("loop_step", 1, 5, 1'b1, 1'b0, 1'b1);
        repeat (32) tick();
        check("loop_hold", 2, 15, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst", 0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 799) == 0);
            start     = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 399) == 0);
            step_size = DB'($urandom);
            if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
            tick();
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
- Controller that sequences a PWM output through a fade ("breathing") cycle: ramp duty up, hold high, ramp down, hold low.
- Contains a prescaler, a PWM slot counter and compare, and the fade FSM.
- Sits between CLOCK_50 and the LEDR drivers on the DE2 top level.
- Replaces the fixed-rate PWM clock divider with a configurable, start/stop-controlled brightness sequencer.

Parameters:
- MAIN_FREQ, 50000000: input clock frequency in Hz.
- PWM_FREQ, 5000: target PWM period frequency in Hz.
- DUTY_BITS, 8: duty resolution. A PWM period has 2^DUTY_BITS slots.
- STEP_PERIODS, 4: PWM periods between duty steps while ramping (>=1).
- HOLD_PERIODS, 50: PWM periods spent in each hold state (>=1).
- Derived localparam DIV = MAIN_FREQ/(PWM_FREQ<<DUTY_BITS), integer division, clamped to a minimum of 1. DIV is the CLOCK_50 cycles per slot.

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a fade sequence.
- stop  in  1  abort request; returns the block to idle.
- loop_en  in  1  when 1, the cycle repeats; when 0, one cycle runs, then done.
- step_size  in  DUTY_BITS  duty increment/decrement per step. Sampled at start.
- pwm_out  out  1  registered PWM output.
- duty  out  DUTY_BITS  current duty value.
- phase  out  3  0=IDLE, 1=RAMP_UP, 2=HOLD_HIGH, 3=RAMP_DOWN, 4=HOLD_LOW.
- busy  out  1  high whenever phase != IDLE.
- done  out  1  one-cycle pulse when a non-looping sequence completes.

Behaviour:
- Reset: synchronous. All state clears: FSM=IDLE, prescaler=0, slot=0, duty=0, pwm_out=0, busy=0, done=0, step/hold counters=0. Reset wins over all other inputs, including mid-sequence.
- Prescaler: tick_cnt counts 0..DIV-1 and wraps. slot_tick is asserted when tick_cnt==DIV-1. The prescaler runs only when busy; it is held at 0 in IDLE.
- Slot counter:
  - DUTY_BITS wide; increments on slot_tick and wraps from max to 0.
  - period_end = slot_tick AND slot==2^DUTY_BITS-1.
- pwm_out: registered, pwm_out <= busy_next AND (slot_next < duty). In each full period it is high for exactly duty*DIV cycles.
  - duty=0 gives constant low.
  - duty=max gives high for all but one slot.
- Duty changes only at period_end, so there is never a partial-period glitch.
- Start acceptance:
  - Accepted only in IDLE with stop=0.
  - Next cycle: phase=RAMP_UP, busy=1, prescaler/slot/step counters are 0, duty=0.
  - Latch step_eff = (step_size==0) ? 1 : step_size.
- start while busy: ignored. step_size changes while busy: ignored.
- stop: in any non-IDLE state, next cycle goes to IDLE with duty=0, pwm_out=0, busy=0 and no done pulse. stop and start in the same IDLE cycle: stop wins and the block stays IDLE.
- RAMP_UP: every STEP_PERIODS period_ends, duty <= min(duty+step_eff, max), computed one bit wider to avoid overflow. When the new duty equals max, go to HOLD_HIGH on the same edge and clear the hold counter.
- HOLD_HIGH: counts period_ends. On the HOLD_PERIODS-th one, go to RAMP_DOWN. Duty stays at max.
- RAMP_DOWN: every STEP_PERIODS period_ends, duty <= max(duty-step_eff, 0), saturating with no underflow. When the new duty equals 0, go to HOLD_LOW.
- HOLD_LOW: on the HOLD_PERIODS-th period_end:
  - loop_en=1: go to RAMP_UP (step counter cleared, no done).
  - loop_en=0: go to IDLE and pulse done for exactly one cycle on that edge.
  - loop_en is sampled at that edge.
- Latency: start to first pwm_out high (step≥1) is STEP_PERIODS full periods plus 1 cycle.
- No combinational path from any input to any output.

Test Plan:
Bench parameters for all scenarios: MAIN_FREQ=64, PWM_FREQ=4, DUTY_BITS=4 (DIV=1, 16-cycle period), STEP_PERIODS=1, HOLD_PERIODS=2.
1. Reset: assert rst for 3 cycles after random activity -> pwm_out=0, duty=0, phase=0, busy=0, done=0.
2. Single fade: start pulse, step_size=5, loop_en=0.
   - duty after successive period_ends: 5, 10, 15, then HOLD_HIGH for 2 periods.
   - Then 10, 5, 0, then HOLD_LOW for 2 periods.
   - done pulses for exactly 1 cycle, then phase=0.
   - pwm_out high-cycle count per period equals duty (0, 5, 10, 15, ...).
3. Zero step: step_size=0 -> ramps by 1. duty reaches 15 after 15 period_ends; phase goes 1->2 on that edge.
4. Abort: stop asserted in RAMP_DOWN with duty=10 -> next cycle phase=0, duty=0, pwm_out=0, done never asserted.
5. Conflicts:
   - start and stop asserted together in IDLE -> stays IDLE.
   - start re-asserted during RAMP_UP with step_size=3 -> ignored; sequence continues with step 5.
6. Loop and mid-run reset:
   - loop_en=1 -> after HOLD_LOW, phase=1 again, duty 0->5, done=0.
   - rst asserted during HOLD_HIGH -> next cycle all outputs at reset values.
